// File: rtl/svm_sv_rom_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : svm_sv_rom_streamer
//  Description : Support-vector ROM bank array with a command-driven row
//                walker. Rows are read from NUM_BANKS parallel 1-cycle ROM
//                macros sharing one address and are delivered through a small
//                output FIFO over a valid/ready stream. Reads are only issued
//                when the FIFO is guaranteed to have room for them, so
//                downstream backpressure never drops a row.
//  Revision    : 1.0 - initial release
// ============================================================================
module svm_sv_rom_streamer #(
    parameter int NUM_BANKS       = 16,
    parameter int ROM_WIDTH       = 128,
    parameter int ROM_DEPTH       = 1024,
    parameter int LOG_ROM_DEPTH   = 10,
    parameter int FIFO_DEPTH      = 4,
    parameter int ROM_TOTAL_WIDTH = NUM_BANKS * ROM_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LOG_ROM_DEPTH-1:0]   base_addr,
    input  logic [LOG_ROM_DEPTH:0]     len,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROM_TOTAL_WIDTH-1:0] out_data,
    output logic                       out_last,
    output logic [LOG_ROM_DEPTH-1:0]   out_index
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_len_w = LOG_ROM_DEPTH + 1;
    localparam logic [c_len_w-1:0] c_depth = c_len_w'(ROM_DEPTH);

    // Command / walker state
    logic [1:0]               r_state;
    logic [LOG_ROM_DEPTH-1:0] r_base;
    logic [c_len_w-1:0]       r_len;
    logic [c_len_w-1:0]       r_issued;
    logic                     r_done;

    // Tag of the read currently inside the ROM macros
    logic                     r_rd_valid;
    logic                     r_rd_last;
    logic [LOG_ROM_DEPTH-1:0] r_rd_index;

    // Output FIFO storage
    logic [ROM_TOTAL_WIDTH-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [LOG_ROM_DEPTH-1:0]   r_fifo_index [FIFO_DEPTH];
    logic                       r_fifo_last  [FIFO_DEPTH];
    logic [c_ptr_w-1:0]         r_wptr;
    logic [c_ptr_w-1:0]         r_rptr;
    logic [c_cnt_w-1:0]         r_fifo_count;

    logic                       w_flush;
    logic                       w_room;
    logic                       w_issue;
    logic                       w_issue_last;
    logic                       w_push;
    logic                       w_pop;
    logic [c_len_w-1:0]         w_sum;
    logic [LOG_ROM_DEPTH-1:0]   w_addr;
    logic [NUM_BANKS-1:0]       w_ceb;
    logic [ROM_TOTAL_WIDTH-1:0] w_q;
    logic [c_ptr_w-1:0]         w_wptr_nxt;
    logic [c_ptr_w-1:0]         w_rptr_nxt;

    // Abort only matters while a command is active.
    assign w_flush = abort && (r_state != c_st_idle);

    // Room check counts the FIFO occupancy before any pop this cycle plus the
    // read still inside the macros, so every issued read has a slot waiting.
    assign w_room  = (32'(r_fifo_count) + 32'(r_rd_valid)) < 32'(FIFO_DEPTH);
    assign w_issue = (r_state == c_st_issue) && !abort && (r_issued < r_len) && w_room;
    assign w_issue_last = (r_issued + c_len_w'(1)) == r_len;

    // Row address wraps modulo ROM_DEPTH; base and offset are both below
    // ROM_DEPTH so one conditional subtraction is enough.
    assign w_sum  = {1'b0, r_base} + r_issued;
    assign w_addr = (w_sum >= c_depth) ? LOG_ROM_DEPTH'(w_sum - c_depth)
                                       : LOG_ROM_DEPTH'(w_sum);
    assign w_ceb  = {NUM_BANKS{~w_issue}};

    assign w_push = r_rd_valid && !w_flush;
    assign w_pop  = out_valid && out_ready;

    assign w_wptr_nxt = (r_wptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    // ROM macros; bank 0 lands in the most significant slice of the row.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        svm_sv_rom_bank #(
            .ROM_WIDTH     (ROM_WIDTH),
            .LOG_ROM_DEPTH (LOG_ROM_DEPTH),
            .BANK          (b)
        ) u_rom (
            .clk (clk),
            .ceb (w_ceb[b]),
            .a   (w_addr),
            .q   (w_q[(NUM_BANKS-1-b)*ROM_WIDTH +: ROM_WIDTH])
        );
    end

    // Command FSM: accepts starts, walks the rows, retires on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_index <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_index <= LOG_ROM_DEPTH'(r_issued);
                r_rd_last  <= w_issue_last;
            end
            case (r_state)
                c_st_idle: begin
                    if (start && !abort) begin
                        if (len != '0) begin
                            r_state  <= c_st_issue;
                            r_base   <= base_addr;
                            r_len    <= len;
                            r_issued <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_issue: begin
                    if (abort) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end else if (w_issue) begin
                        r_issued <= r_issued + c_len_w'(1);
                        if (w_issue_last) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (abort) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end else if (w_pop && out_last) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Output FIFO: captures each ROM row the cycle its Q is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_index[i] <= '0;
                r_fifo_last[i]  <= 1'b0;
            end
        end else if (w_flush) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr]  <= w_q;
                r_fifo_index[r_wptr] <= r_rd_index;
                r_fifo_last[r_wptr]  <= r_rd_last;
                r_wptr               <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            r_fifo_count <= r_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign done      = r_done;
    assign out_valid = (r_fifo_count != '0);
    assign out_data  = r_fifo_data[r_rptr];
    assign out_index = r_fifo_index[r_rptr];
    assign out_last  = r_fifo_last[r_rptr];

endmodule

// ============================================================================
//  Module      : svm_sv_rom_bank
//  Description : Behavioural model of one synchronous ROM macro. Active-low
//                chip enable, one cycle read latency, Q holds its value when
//                not enabled. Row contents are (bank << 16) | row.
//  Revision    : 1.0 - initial release
// ============================================================================
module svm_sv_rom_bank #(
    parameter int ROM_WIDTH     = 128,
    parameter int LOG_ROM_DEPTH = 10,
    parameter int BANK          = 0
) (
    input  logic                     clk,
    input  logic                     ceb,
    input  logic [LOG_ROM_DEPTH-1:0] a,
    output logic [ROM_WIDTH-1:0]     q
);

    localparam logic [ROM_WIDTH-1:0] c_bank_tag = ROM_WIDTH'(BANK) << 16;

    // Read port: Q updates only on enabled cycles.
    always_ff @(posedge clk) begin
        if (!ceb) begin
            q <= c_bank_tag | ROM_WIDTH'(a);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_svm_sv_rom_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_svm_sv_rom_streamer
//  Description : Self-checking bench for svm_sv_rom_streamer. Expected rows
//                come from the ROM content rule and modular row arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_svm_sv_rom_streamer;

    localparam int NB = 16;
    localparam int W  = 128;
    localparam int D  = 1024;
    localparam int LD = 10;
    localparam int FD = 4;
    localparam int TW = NB * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LD-1:0] base_addr;
    logic [LD:0]   len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_data;
    logic          out_last;
    logic [LD-1:0] out_index;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [TW-1:0] data;
        logic [LD-1:0] index;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t beats[$];
    int    done_cyc[$];
    int    ceb_low[NB];
    int    max_count;
    int    stall_viol;
    int    valid_cnt;

    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_data;
    logic [LD-1:0] prev_index;
    logic          prev_last;

    svm_sv_rom_streamer #(
        .NUM_BANKS     (NB),
        .ROM_WIDTH     (W),
        .ROM_DEPTH     (D),
        .LOG_ROM_DEPTH (LD),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_index (out_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the stream mid-cycle: handshakes, done pulses, bank enables.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                if (!out_valid || out_data !== prev_data ||
                    out_index !== prev_index || out_last !== prev_last)
                    stall_viol++;
            end
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready)
                beats.push_back('{out_data, out_index, out_last, cyc});
            if (done) done_cyc.push_back(cyc);
            for (int b = 0; b < NB; b++)
                if (dut.w_ceb[b] == 1'b0) ceb_low[b]++;
            if (int'(dut.r_fifo_count) > max_count) max_count = int'(dut.r_fifo_count);
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_data  = out_data;
        prev_index = out_index;
        prev_last  = out_last;
    end

    function automatic logic [TW-1:0] exp_row(int row);
        logic [TW-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++)
            v[(NB-1-b)*W +: W] = W'((b << 16) | row);
        return v;
    endfunction

    // Number of received beats that disagree with a walk of n rows from base.
    function automatic int model_errors(int base, int n);
        int e;
        int row;
        e = 0;
        if (beats.size() != n) e++;
        for (int i = 0; i < beats.size() && i < n; i++) begin
            row = (base + i) % D;
            if (beats[i].data !== exp_row(row) || beats[i].index !== LD'(i) ||
                beats[i].last !== (i == n - 1))
                e++;
        end
        return e;
    endfunction

    task automatic clear_stats();
        beats.delete();
        done_cyc.delete();
        for (int b = 0; b < NB; b++) ceb_low[b] = 0;
        max_count  = 0;
        stall_viol = 0;
        valid_cnt  = 0;
    endtask

    // mode 0: ready always high, 1: toggle 1010..., 2: random
    task automatic run_cmd(input int b, input int l, input int mode, input int budget,
                           output int t0, output bit to);
        @(posedge clk); #1;
        base_addr = LD'(b);
        len       = (LD+1)'(l);
        start     = 1'b1;
        t0        = cyc;
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        to        = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                to = 1'b0;
                break;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        @(negedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== '0) $display("FAIL reset_stream: valid=%b last=%b index=%0d required 0 0 0", out_valid, out_last, out_index); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_data: low=%h required 0", out_data[63:0]); else n_pass++;
        n_checks++; if (dut.w_ceb !== {NB{1'b1}}) $display("FAIL reset_ceb: got %h required all ones", dut.w_ceb); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL post_reset_idle: busy=%b valid=%b required 0 0", busy, out_valid); else n_pass++;
    endtask

    task automatic test_basic();
        int t0; bit to; int e;
        clear_stats();
        run_cmd(5, 3, 0, 50, t0, to);
        n_checks++; if (to) $display("FAIL basic_timeout: no done within budget"); else n_pass++;
        e = model_errors(5, 3);
        n_checks++; if (e !== 0) $display("FAIL basic_rows: %0d bad beats of %0d, required 0", e, beats.size()); else n_pass++;
        e = 0;
        for (int i = 0; i < beats.size(); i++) if (beats[i].cyc != t0 + 3 + i) e++;
        n_checks++; if (e !== 0) $display("FAIL basic_latency: %0d beats off schedule (first at %0d, start %0d)", e, (beats.size() > 0) ? beats[0].cyc : -1, t0); else n_pass++;
        n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 6) $display("FAIL basic_done: %0d pulses, first at %0d, required 1 at %0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t0 + 6); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle: busy=%b required 0", busy); else n_pass++;
    endtask

    task automatic test_wrap();
        int t0; bit to; int e;
        clear_stats();
        run_cmd(D - 2, 4, 0, 50, t0, to);
        n_checks++; if (to) $display("FAIL wrap_timeout: no done within budget"); else n_pass++;
        e = model_errors(D - 2, 4);
        n_checks++; if (e !== 0) $display("FAIL wrap_rows: %0d bad beats of %0d, required 0", e, beats.size()); else n_pass++;
        e = 0;
        for (int i = 0; i < beats.size(); i++) if (beats[i].cyc != t0 + 3 + i) e++;
        n_checks++; if (e !== 0) $display("FAIL wrap_gaps: %0d beats off schedule, required 0", e); else n_pass++;
        e = 0;
        for (int b = 0; b < NB; b++) if (ceb_low[b] != 4) e++;
        n_checks++; if (e !== 0) $display("FAIL wrap_bank_reads: %0d banks not read 4 times (bank0=%0d)", e, ceb_low[0]); else n_pass++;
    endtask

    task automatic test_backpressure();
        int t0; bit to; int e; int base;
        clear_stats();
        base = int'($urandom_range(0, D - 1));
        run_cmd(base, 8, 1, 100, t0, to);
        n_checks++; if (to) $display("FAIL bp_timeout: no done within budget"); else n_pass++;
        e = model_errors(base, 8);
        n_checks++; if (e !== 0) $display("FAIL bp_rows: %0d bad beats of %0d, base %0d, required 0", e, beats.size(), base); else n_pass++;
        n_checks++; if (stall_viol !== 0) $display("FAIL bp_stable: %0d stall violations, required 0", stall_viol); else n_pass++;
        n_checks++; if (ceb_low[0] !== 8) $display("FAIL bp_ceb: %0d enabled cycles, required 8", ceb_low[0]); else n_pass++;
        n_checks++; if (max_count > FD) $display("FAIL bp_fifo: max count %0d, required <= %0d", max_count, FD); else n_pass++;
    endtask

    task automatic test_len_zero();
        int t0; bit to;
        clear_stats();
        run_cmd(77, 0, 0, 10, t0, to);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 1) $display("FAIL len0_done: %0d pulses, first at %0d, required 1 at %0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t0 + 1); else n_pass++;
        n_checks++; if (valid_cnt !== 0 || ceb_low[0] !== 0) $display("FAIL len0_quiet: valid cycles %0d reads %0d, required 0 0", valid_cnt, ceb_low[0]); else n_pass++;
    endtask

    task automatic test_start_busy();
        bit got; int e;
        clear_stats();
        @(posedge clk); #1;
        base_addr = LD'(200); len = (LD+1)'(6); start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        base_addr = LD'(500); len = (LD+1)'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (done) begin got = 1'b1; break; end
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (!got) $display("FAIL busy_timeout: no done within budget"); else n_pass++;
        e = model_errors(200, 6);
        n_checks++; if (e !== 0) $display("FAIL busy_rows: %0d bad beats of %0d, required 0 of 6", e, beats.size()); else n_pass++;
        n_checks++; if (done_cyc.size() !== 1 || ceb_low[0] !== 6 || busy !== 1'b0) $display("FAIL busy_ignored: pulses %0d reads %0d busy %b, required 1 6 0", done_cyc.size(), ceb_low[0], busy); else n_pass++;
    endtask

    task automatic test_abort();
        int t0; bit to; bit got; int e;
        clear_stats();
        @(posedge clk); #1;
        base_addr = LD'(20); len = (LD+1)'(10); start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (beats.size() >= 2) begin got = 1'b1; break; end
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (!got || out_valid !== 1'b1 || out_index !== LD'(2)) $display("FAIL abort_pre: valid=%b index=%0d required 1 2", out_valid, out_index); else n_pass++;
        abort = 1'b1;
        start = 1'b1; base_addr = LD'(300); len = (LD+1)'(5);
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL abort_flush: valid=%b done=%b busy=%b required 0 1 0", out_valid, done, busy); else n_pass++;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (done_cyc.size() !== 1 || beats.size() !== 2 || busy !== 1'b0) $display("FAIL abort_after: pulses %0d beats %0d busy %b, required 1 2 0", done_cyc.size(), beats.size(), busy); else n_pass++;
        clear_stats();
        run_cmd(0, 1, 0, 50, t0, to);
        e = model_errors(0, 1);
        n_checks++; if (to || e !== 0) $display("FAIL abort_restart: timeout %b bad beats %0d of %0d, required 0 0 of 1", to, e, beats.size()); else n_pass++;
    endtask

    task automatic test_full_len();
        int t0; bit to; int e; int base;
        clear_stats();
        base = int'($urandom_range(0, D - 1));
        run_cmd(base, D, 0, 1500, t0, to);
        e = model_errors(base, D);
        n_checks++; if (to || e !== 0) $display("FAIL full_rows: timeout %b bad beats %0d of %0d, required 0 0 of %0d", to, e, beats.size(), D); else n_pass++;
        n_checks++; if (ceb_low[0] !== D) $display("FAIL full_reads: %0d reads, required %0d", ceb_low[0], D); else n_pass++;
    endtask

    task automatic test_random();
        int t0; bit to; int e; int base; int l;
        for (int it = 0; it < 4; it++) begin
            clear_stats();
            base = int'($urandom_range(0, D - 1));
            l    = int'($urandom_range(1, 40));
            run_cmd(base, l, 2, 500, t0, to);
            e = model_errors(base, l);
            n_checks++; if (to || e !== 0) $display("FAIL rand_rows[%0d]: base %0d len %0d timeout %b bad %0d", it, base, l, to, e); else n_pass++;
            n_checks++; if (ceb_low[0] !== l || done_cyc.size() !== 1 || stall_viol !== 0) $display("FAIL rand_misc[%0d]: reads %0d pulses %0d viol %0d, required %0d 1 0", it, ceb_low[0], done_cyc.size(), stall_viol, l); else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        int t0; bit to; int e;
        clear_stats();
        @(posedge clk); #1;
        base_addr = LD'(100); len = (LD+1)'(3); start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || int'(dut.r_fifo_count) !== 3) $display("FAIL rst_pre: busy=%b valid=%b count=%0d required 1 1 3", busy, out_valid, dut.r_fifo_count); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== '0) $display("FAIL rst_async: busy=%b done=%b valid=%b last=%b index=%0d required all 0", busy, done, out_valid, out_last, out_index); else n_pass++;
        n_checks++; if (out_data !== '0 || dut.w_ceb !== {NB{1'b1}}) $display("FAIL rst_async_data: low=%h ceb=%h required 0 and all ones", out_data[63:0], dut.w_ceb); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (done_cyc.size() !== 0 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_no_done: pulses %0d valid %b busy %b required 0 0 0", done_cyc.size(), out_valid, busy); else n_pass++;
        clear_stats();
        run_cmd(3, 2, 0, 50, t0, to);
        e = model_errors(3, 2);
        n_checks++; if (to || e !== 0) $display("FAIL rst_recover: timeout %b bad %0d of %0d, required 0 0 of 2", to, e, beats.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_start_busy();
        test_abort();
        test_full_len();
        test_random();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
